// File: rtl/dmem_mmio_pkg.sv
// rtl/dmem_mmio_pkg.sv - MMIO address map and STATUS layout for the data-side memory responder
package dmem_mmio_pkg;

    localparam logic [31:0] MMIO_BASE   = 32'hFFFF_FF00;
    localparam logic [7:0]  CYCLE_OFS   = 8'h00;
    localparam logic [7:0]  COMPARE_OFS = 8'h04;
    localparam logic [7:0]  STATUS_OFS  = 8'h08;
    localparam logic [7:0]  CONS_OFS    = 8'h0C;

    // First member lands in the MSB, so this packs as {overflow, misalign, empty, full, hit}.
    typedef struct packed {
        logic overflow;
        logic misalign;
        logic fifo_empty;
        logic fifo_full;
        logic timer_hit;
    } status_t;

endpackage

// File: rtl/byte_fifo.sv
// rtl/byte_fifo.sv - byte FIFO for the console TX path; caller gates push so it never overflows
module byte_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push_i,
    input  logic [7:0]             push_data_i,
    input  logic                   pop_i,
    output logic [7:0]             head_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int PW = $clog2(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q;
    logic [PW-1:0] wr_ptr_q;
    logic [PW:0]   count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + (PW+1)'(1);
                2'b01:   count_q <= count_q - (PW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (PW+1)'(DEPTH));
    assign count_o = count_q;
    assign head_o  = empty_o ? 8'h00 : mem_q[rd_ptr_q];

endmodule

// File: rtl/dmem_mmio.sv
// rtl/dmem_mmio.sv - word RAM plus cycle/timer/console MMIO page for the single-cycle core
// Optional: MISALIGN_CHK_EN flags and suppresses accesses with addr[1:0] != 0.
module dmem_mmio
    import dmem_mmio_pkg::*;
#(
    parameter int RAM_WORDS  = 64,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] addr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        cons_valid,
    output logic [7:0]  cons_data,
    input  logic        cons_ready,
    output logic        timer_irq
);
    localparam int AW = $clog2(RAM_WORDS);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [31:0] ram [RAM_WORDS];

    logic [31:0] cycle_q, cycle_d;
    logic [31:0] compare_q, compare_d;
    logic        timer_hit_q, timer_hit_d;
    logic        misalign_q, misalign_d;
    logic        overflow_q, overflow_d;

    logic          misalign_now;
    logic          ram_sel, mmio_sel;
    logic [7:0]    mmio_ofs;
    logic [AW-1:0] ram_idx;
    logic          wr_ok, ram_we, compare_we, status_we, cons_push_req;
    logic          fifo_pop, fifo_push, push_drop;
    logic          fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;
    status_t       status;

`ifdef MISALIGN_CHK_EN
    assign misalign_now = (addr[1:0] != 2'b00);
`else
    logic unused_addr_lo;
    assign misalign_now   = 1'b0;
    assign unused_addr_lo = ^addr[1:0];
`endif

    assign ram_sel  = (addr[31:AW+2] == '0);
    assign mmio_sel = (addr[31:8] == MMIO_BASE[31:8]) && (addr[7:4] == 4'h0);
    assign mmio_ofs = {addr[7:2], 2'b00};
    assign ram_idx  = addr[AW+1:2];

    assign wr_ok         = memwrite & ~misalign_now;
    assign ram_we        = wr_ok & ram_sel;
    assign compare_we    = wr_ok & mmio_sel & (mmio_ofs == COMPARE_OFS);
    assign status_we     = wr_ok & mmio_sel & (mmio_ofs == STATUS_OFS);
    assign cons_push_req = wr_ok & mmio_sel & (mmio_ofs == CONS_OFS);

    // A pop in the same cycle frees a slot, so a full FIFO can still take the byte.
    assign fifo_pop  = cons_valid & cons_ready;
    assign fifo_push = cons_push_req & ((fifo_count < CW'(FIFO_DEPTH)) | fifo_pop);
    assign push_drop = cons_push_req & ~fifo_push;

    byte_fifo #(.DEPTH(FIFO_DEPTH)) u_cons_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (fifo_push),
        .push_data_i (writedata[7:0]),
        .pop_i       (fifo_pop),
        .head_o      (cons_data),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[ram_idx] <= writedata;
        end
    end

    // Sticky bits: a set event in the same cycle as its write-1-clear wins.
    always_comb begin
        cycle_d     = cycle_q + 32'd1;
        compare_d   = compare_we ? writedata : compare_q;
        timer_hit_d = timer_hit_q & ~(status_we & writedata[0]);
        if ((cycle_q == compare_q) && (compare_q != '0)) begin
            timer_hit_d = 1'b1;
        end
        misalign_d  = (misalign_q & ~(status_we & writedata[3])) | misalign_now;
        overflow_d  = (overflow_q & ~(status_we & writedata[4])) | push_drop;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_q     <= '0;
            compare_q   <= '0;
            timer_hit_q <= 1'b0;
            misalign_q  <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            cycle_q     <= cycle_d;
            compare_q   <= compare_d;
            timer_hit_q <= timer_hit_d;
            misalign_q  <= misalign_d;
            overflow_q  <= overflow_d;
        end
    end

    always_comb begin
        status.overflow   = overflow_q;
        status.misalign   = misalign_q;
        status.fifo_empty = fifo_empty;
        status.fifo_full  = fifo_full;
        status.timer_hit  = timer_hit_q;
    end

    always_comb begin
        readdata = 32'h0;
        if (misalign_now) begin
            readdata = 32'h0;
        end else if (ram_sel) begin
            readdata = ram[ram_idx];
        end else if (mmio_sel) begin
            case (mmio_ofs)
                CYCLE_OFS:   readdata = cycle_q;
                COMPARE_OFS: readdata = compare_q;
                STATUS_OFS:  readdata = {27'd0, status};
                default:     readdata = 32'h0;
            endcase
        end
    end

    assign cons_valid = ~fifo_empty;
    assign timer_irq  = timer_hit_q;

endmodule

// File: tb/tb_dmem_mmio.sv
// tb/tb_dmem_mmio.sv - scoreboard bench for dmem_mmio: directed loads/stores, timer, console FIFO, reset
module tb_dmem_mmio;

    localparam logic [31:0] A_CYCLE   = 32'hFFFF_FF00;
    localparam logic [31:0] A_COMPARE = 32'hFFFF_FF04;
    localparam logic [31:0] A_STATUS  = 32'hFFFF_FF08;
    localparam logic [31:0] A_CONS    = 32'hFFFF_FF0C;

    localparam int S_RD   = 0;
    localparam int S_VAL  = 1;
    localparam int S_IRQ  = 2;
    localparam int S_DATA = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        memwrite;
    logic [31:0] addr;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        cons_valid;
    logic [7:0]  cons_data;
    logic        cons_ready;
    logic        timer_irq;

    int checks = 0;
    int errors = 0;
    int tb_cyc = 0;

    int          sel_q [$];
    logic [31:0] val_q [$];
    int          cyc_q [$];
    string       name_q [$];
    logic [7:0]  cons_q [$];

    dmem_mmio #(.RAM_WORDS(64), .FIFO_DEPTH(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .memwrite   (memwrite),
        .addr       (addr),
        .writedata  (writedata),
        .readdata   (readdata),
        .cons_valid (cons_valid),
        .cons_data  (cons_data),
        .cons_ready (cons_ready),
        .timer_irq  (timer_irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) tb_cyc <= tb_cyc + 1;

    // Scoreboard monitor for register-style outputs, sampled mid-cycle.
    int          m_sel;
    int          m_cyc;
    logic [31:0] m_exp;
    logic [31:0] m_act;
    string       m_name;
    always @(negedge clk) begin
        while (cyc_q.size() > 0 && cyc_q[0] <= tb_cyc) begin
            m_sel  = sel_q.pop_front();
            m_exp  = val_q.pop_front();
            m_cyc  = cyc_q.pop_front();
            m_name = name_q.pop_front();
            checks++;
            case (m_sel)
                S_RD:    m_act = readdata;
                S_VAL:   m_act = {31'd0, cons_valid};
                S_IRQ:   m_act = {31'd0, timer_irq};
                default: m_act = {24'd0, cons_data};
            endcase
            if (m_cyc < tb_cyc) begin
                errors++;
                $display("FAIL %s missed its sampling cycle (%0d now %0d)", m_name, m_cyc, tb_cyc);
            end else if (m_act !== m_exp) begin
                errors++;
                $display("FAIL %s actual=%h required=%h", m_name, m_act, m_exp);
            end
        end
    end

    // Console drain monitor: every accepted byte must match the next expected byte.
    logic [7:0] c_exp;
    always @(negedge clk) begin
        if (!reset && cons_valid && cons_ready) begin
            checks++;
            if (cons_q.size() == 0) begin
                errors++;
                $display("FAIL cons_drain unexpected byte actual=%h required=none", cons_data);
            end else begin
                c_exp = cons_q.pop_front();
                if (cons_data !== c_exp) begin
                    errors++;
                    $display("FAIL cons_drain actual=%h required=%h", cons_data, c_exp);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input int sel, input logic [31:0] v, input string nm);
        sel_q.push_back(sel);
        val_q.push_back(v);
        cyc_q.push_back(tb_cyc);
        name_q.push_back(nm);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr      = a;
        writedata = d;
        memwrite  = 1'b1;
        cyc();
        memwrite  = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] v, input string nm);
        addr     = a;
        memwrite = 1'b0;
        chk(S_RD, v, nm);
        cyc();
    endtask

    task automatic push_byte(input logic [7:0] b, input logic accepted);
        if (accepted) cons_q.push_back(b);
        wr(A_CONS, {24'hABCD_00, b});
    endtask

    initial begin
        reset      = 1'b1;
        memwrite   = 1'b0;
        addr       = 32'h0;
        writedata  = 32'h0;
        cons_ready = 1'b0;
        repeat (3) cyc();
        reset = 1'b0;

        // Reset state
        addr = A_CYCLE;
        chk(S_RD, 32'd0, "rst_cycle");
        chk(S_VAL, 32'd0, "rst_cons_valid");
        chk(S_IRQ, 32'd0, "rst_irq");
        chk(S_DATA, 32'd0, "rst_cons_data");
        cyc();
        rd(A_STATUS, 32'h4, "rst_status");
        rd(A_COMPARE, 32'h0, "rst_compare");

        // RAM store/load, top word, out-of-range aliasing
        wr(32'h14, 32'h1234_5678);
        wr(32'h10, 32'hDEAD_BEEF);
        rd(32'h10, 32'hDEAD_BEEF, "ram_rw");
        rd(32'h14, 32'h1234_5678, "ram_neighbour");
        wr(32'hFC, 32'hA5A5_5A5A);
        rd(32'hFC, 32'hA5A5_5A5A, "ram_top_word");
        wr(32'h00, 32'h0000_0011);
        wr(32'h100, 32'h0000_0022);
        rd(32'h00, 32'h0000_0011, "ram_no_alias");
        rd(32'h100, 32'h0, "unmapped_low");
        rd(32'hFFFF_FF10, 32'h0, "unmapped_mmio");

        // Misaligned store
        wr(32'h12, 32'h55AA_55AA);
`ifdef MISALIGN_CHK_EN
        rd(32'h10, 32'hDEAD_BEEF, "misalign_suppressed");
        rd(A_STATUS, 32'hC, "misalign_status");
`else
        rd(32'h10, 32'h55AA_55AA, "misalign_ignored");
        rd(A_STATUS, 32'h4, "misalign_status");
`endif

        // Timer: COMPARE=20 right after reset
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        wr(A_COMPARE, 32'd20);
        addr = 32'h0;
        repeat (19) cyc();
        addr = A_CYCLE;
        chk(S_RD, 32'd20, "timer_cycle20");
        chk(S_IRQ, 32'd0, "irq_before_hit");
        cyc();
        chk(S_RD, 32'd21, "timer_cycle21");
        chk(S_IRQ, 32'd1, "irq_on_hit");
        cyc();
        addr      = A_STATUS;
        writedata = 32'h1;
        memwrite  = 1'b1;
        chk(S_RD, 32'h5, "status_timer_hit");
        chk(S_IRQ, 32'd1, "irq_during_clear");
        cyc();
        memwrite = 1'b0;
        chk(S_RD, 32'h4, "status_after_clear");
        chk(S_IRQ, 32'd0, "irq_cleared");
        cyc();
        rd(A_COMPARE, 32'd20, "compare_readback");

        // Console overflow: 9 pushes into 8 entries with the sink stalled
        cons_ready = 1'b0;
        for (int i = 0; i < 9; i++) push_byte(8'h41 + 8'(i), i < 8);
        chk(S_DATA, 32'h41, "head_held_1");
        rd(A_STATUS, 32'h12, "fifo_full_overflow");
        chk(S_DATA, 32'h41, "head_held_2");
        rd(A_CONS, 32'h0, "cons_reads_zero");
        addr = 32'h0;
        cons_ready = 1'b1;
        repeat (8) cyc();
        chk(S_VAL, 32'd0, "drained_valid_low");
        cyc();
        wr(A_STATUS, 32'h10);
        rd(A_STATUS, 32'h4, "overflow_cleared");

        // Full FIFO with simultaneous pop and push
        cons_ready = 1'b0;
        for (int i = 0; i < 8; i++) push_byte(8'h50 + 8'(i), 1'b1);
        cons_ready = 1'b1;
        push_byte(8'h58, 1'b1);
        cons_ready = 1'b0;
        rd(A_STATUS, 32'h2, "full_pop_push_no_ovf");
        addr = 32'h0;
        cons_ready = 1'b1;
        repeat (8) cyc();
        chk(S_VAL, 32'd0, "drained2_valid_low");
        cyc();

        // Reset mid-operation with 3 bytes queued at CYCLE=1000
        cons_ready = 1'b0;
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        addr = 32'h0;
        repeat (997) cyc();
        for (int i = 0; i < 3; i++) push_byte(8'h61 + 8'(i), 1'b1);
        addr = A_CYCLE;
        chk(S_RD, 32'd1000, "cycle_1000");
        chk(S_VAL, 32'd1, "valid_before_reset");
        cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        cons_q.delete();
        addr = A_CYCLE;
        chk(S_RD, 32'd0, "cycle_after_reset");
        chk(S_VAL, 32'd0, "valid_after_reset");
        cyc();
        rd(A_STATUS, 32'h4, "status_after_reset");
        rd(A_CYCLE, 32'd2, "cycle_increments");

        addr = 32'h0;
        repeat (2) cyc();
        checks++;
        if (cons_q.size() != 0) begin
            errors++;
            $display("FAIL cons_leftover actual=%0d required=0", cons_q.size());
        end
        checks++;
        if (cyc_q.size() != 0) begin
            errors++;
            $display("FAIL checks_pending actual=%0d required=0", cyc_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
